wb_vec_writer: RTL
==================

WB_VEC_WRITER -- requirements
Module: wb_vec_writer

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, meaning 32-bit lanes per vector.
REQ-002 SHALL have parameter LANE_W, default 32, meaning lane width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  writeback request present.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid and in_ready are both high at the edge.
REQ-007 SHALL have port in_is_vec  input  1  0 = scalar register file, 1 = vector register file.
REQ-008 SHALL have port in_col_mode  input  1  vector only: 0 = row write, 1 = column write.
REQ-009 SHALL have port in_addr  input  4  destination row or register.
REQ-010 SHALL have port in_col  input  2  destination column for column mode.
REQ-011 SHALL have port in_data  input  NUM_LANES*LANE_W  payload; lane k = bits [32k+31:32k]; scalar uses lane 0.
REQ-012 SHALL have port writeAddr  output  4  register-file write address.
REQ-013 SHALL have port writeData  output  32  write data.
REQ-014 SHALL have port RegWrite  output  1  scalar write enable.
REQ-015 SHALL have port VRegWrite  output  1  vector write enable.
REQ-016 SHALL have port colwrite  output  1  column-addressed vector write.
REQ-017 SHALL have port columna  output  2  column for the current vector beat.
REQ-018 SHALL have port stall  output  1  equals ~in_ready; used to freeze upstream stages.

Function
REQ-019 SHALL implement FSM states IDLE and BURST, with a 2-bit beat counter.
REQ-020 SHALL drive all write-port outputs from registers, so each write appears on the cycle after it is decided.
REQ-021 SHALL accept a scalar request in IDLE and issue one write on the next cycle: RegWrite=1, writeAddr=in_addr, writeData=lane 0; the FSM stays in IDLE.
REQ-022 SHALL suppress RegWrite for a scalar write to address 0; the accept still completes.
REQ-023 SHALL, on an accepted vector request, latch addr, col, mode and data, go to BURST, and issue NUM_LANES beats on consecutive cycles, starting the cycle after accept.
REQ-024 SHALL, for a row-mode beat k: VRegWrite=1, colwrite=1, writeAddr=addr, columna=k, writeData=lane k.
REQ-025 SHALL, for a column-mode beat k: VRegWrite=1, colwrite=1, writeAddr=(addr+k) mod 16, columna=col, writeData=lane k.
REQ-026 SHALL let row-address increments wrap 15 -> 0 without error.
REQ-027 SHALL drive in_ready high in IDLE and during the final beat (k=3), and low on all other BURST beats.
REQ-028 SHALL, on accept during the final beat, begin the new request's first write on the very next cycle (back-to-back, no bubble).
REQ-029 SHALL return to IDLE after the final beat when no new request is accepted.
REQ-030 SHALL never assert RegWrite and VRegWrite on the same cycle.
REQ-031 SHALL hold writeData, writeAddr and columna stable while both enables are low; their values are don't-care but deterministic.
REQ-032 SHALL ignore in_valid while in_ready is low; no request is lost and none is duplicated.

Reset
REQ-033 SHALL, while rst is high at an edge, force state=IDLE, beat=0, and every output 0; in_ready is 0 during the rst cycle and 1 afterwards.
REQ-034 SHALL abort a burst on reset mid-burst with no further beats; the aborted request is not replayed.

Structure
REQ-035 SHALL place the FSM state enum, NUM_LANES and LANE_W in the shared package aes_simd_pkg.
REQ-036 SHALL use the existing Mux #(4,32) for lane selection; no other sub-module.
REQ-037 SHALL fit in 120-400 lines of RTL.

Verification
REQ-038 SHALL cover: scalar, addr=5, lane0=0xDEADBEEF -> next cycle RegWrite=1, writeAddr=5, writeData=0xDEADBEEF, VRegWrite=0.
REQ-039 SHALL cover: scalar to addr 0 -> RegWrite stays 0, in_ready stays 1.
REQ-040 SHALL cover: vector row, addr=3, lanes {0x11111111,0x22222222,0x33333333,0x44444444} -> 4 beats, writeAddr=3, columna=0..3, matching data; in_ready low for beats 0-2.
REQ-041 SHALL cover: vector column, addr=14, col=2 -> writeAddr sequence 14,15,0,1, with columna=2 on every beat.
REQ-042 SHALL cover: a second vector request held valid from the first beat -> accepted only on the final beat; its beat 0 appears on the next cycle, with no gap.
REQ-043 SHALL cover: rst asserted during beat 1 -> the next cycle shows all enables 0 and state IDLE, with no remaining beats.

Source files
------------

// File: rtl/aes_simd_pkg.sv
// Shared definitions for the SIMD writeback path: lane geometry and writer FSM states.
package aes_simd_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 32;
    localparam int ADDR_W    = 4;
    localparam int BEAT_W    = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_vec_writer_mux.sv
// N-way, W-bit lane selector used to pick one lane out of a packed vector.
module Mux #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic [$clog2(N)-1:0] sel,
    input  logic [N-1:0][W-1:0]  d,
    output logic [W-1:0]         y
);

    // Plain indexed select; lane k occupies bits [W*k +: W].
    always_comb begin
        y = d[sel];
    end

endmodule

// File: rtl/wb_vec_writer.sv
// Register-file writeback sequencer: scalar writes go out in one cycle, vector
// writes are serialised into NUM_LANES beats (row or column addressed).
module wb_vec_writer #(
    parameter int NUM_LANES = aes_simd_pkg::NUM_LANES,
    parameter int LANE_W    = aes_simd_pkg::LANE_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_is_vec,
    input  logic                        in_col_mode,
    input  logic [3:0]                  in_addr,
    input  logic [1:0]                  in_col,
    input  logic [NUM_LANES*LANE_W-1:0] in_data,
    output logic [3:0]                  writeAddr,
    output logic [LANE_W-1:0]           writeData,
    output logic                        RegWrite,
    output logic                        VRegWrite,
    output logic                        colwrite,
    output logic [1:0]                  columna,
    output logic                        stall
);

    import aes_simd_pkg::*;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_LANES - 1);

    // FSM and latched request
    wb_state_e                   state, state_n;
    logic [BEAT_W-1:0]           beat, beat_n;
    logic [ADDR_W-1:0]           addr_q, addr_n;
    logic [1:0]                  col_q, col_n;
    logic                        mode_q, mode_n;
    logic [NUM_LANES*LANE_W-1:0] data_q, data_n;

    // Next values for the registered write port
    logic [ADDR_W-1:0]           wa_n;
    logic [LANE_W-1:0]           wd_n;
    logic                        rw_n, vw_n, cw_n;
    logic [1:0]                  ca_n;

    logic                        last_beat, accept;
    logic [BEAT_W-1:0]           beat_inc;
    logic [BEAT_W-1:0]           mux_sel;
    logic [NUM_LANES*LANE_W-1:0] mux_src;
    logic [LANE_W-1:0]           lane;

    assign last_beat = (state == BURST) && (beat == LAST_BEAT);
    // Ready is forced low during the reset cycle so nothing is accepted then.
    assign in_ready  = ~rst && ((state == IDLE) || last_beat);
    assign stall     = ~in_ready;
    assign accept    = in_valid && in_ready;
    assign beat_inc  = beat + 1'b1;

    // A fresh request always starts from lane 0 of the incoming payload;
    // otherwise the next beat's lane comes from the latched copy.
    assign mux_sel = accept ? '0 : beat_inc;
    assign mux_src = accept ? in_data : data_q;

    Mux #(NUM_LANES, LANE_W) u_lane_mux (
        .sel (mux_sel),
        .d   (mux_src),
        .y   (lane)
    );

    // Next-state and next-output decision; the write port holds its address,
    // data and column whenever no enable is raised.
    always_comb begin
        state_n = state;
        beat_n  = beat;
        addr_n  = addr_q;
        col_n   = col_q;
        mode_n  = mode_q;
        data_n  = data_q;
        wa_n    = writeAddr;
        wd_n    = writeData;
        ca_n    = columna;
        rw_n    = 1'b0;
        vw_n    = 1'b0;
        cw_n    = 1'b0;

        if (accept) begin
            beat_n = '0;
            if (in_is_vec) begin
                state_n = BURST;
                addr_n  = in_addr;
                col_n   = in_col;
                mode_n  = in_col_mode;
                data_n  = in_data;
                vw_n    = 1'b1;
                cw_n    = 1'b1;
                wa_n    = in_addr;
                ca_n    = in_col_mode ? in_col : 2'd0;
                wd_n    = lane;
            end else begin
                state_n = IDLE;
                // Register 0 is hardwired; swallow the write but keep the accept.
                if (in_addr != '0) begin
                    rw_n = 1'b1;
                    wa_n = in_addr;
                    wd_n = lane;
                end
            end
        end else if (state == BURST) begin
            if (last_beat) begin
                state_n = IDLE;
                beat_n  = '0;
            end else begin
                beat_n = beat_inc;
                vw_n   = 1'b1;
                cw_n   = 1'b1;
                wa_n   = mode_q ? addr_q + {2'b00, beat_inc} : addr_q;
                ca_n   = mode_q ? col_q : beat_inc;
                wd_n   = lane;
            end
        end
    end

    // State, latched request and write-port registers; reset drops any burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= '0;
            addr_q    <= '0;
            col_q     <= '0;
            mode_q    <= 1'b0;
            data_q    <= '0;
            writeAddr <= '0;
            writeData <= '0;
            columna   <= '0;
            RegWrite  <= 1'b0;
            VRegWrite <= 1'b0;
            colwrite  <= 1'b0;
        end else begin
            state     <= state_n;
            beat      <= beat_n;
            addr_q    <= addr_n;
            col_q     <= col_n;
            mode_q    <= mode_n;
            data_q    <= data_n;
            writeAddr <= wa_n;
            writeData <= wd_n;
            columna   <= ca_n;
            RegWrite  <= rw_n;
            VRegWrite <= vw_n;
            colwrite  <= cw_n;
        end
    end

endmodule
